moving_avg_8tap: RTL
====================

// Module: moving_avg_8tap
// PURPOSE
//  Recursive 8-tap boxcar (moving-sum) filter for the filter_8_tap datapath.
//  The direct-form FIR sums taps through an adder tree; this block instead keeps a running sum.
//  Each cycle it adds the newest sample and subtracts the sample leaving the window.
//  It is the subtract-side counterpart of the signed ripple adder.
//  It sits after the sample source and feeds the decimator or output register stage.
// PARAMETERS
//  DATA_W   7   signed input sample width (two's complement)
//  TAPS_LG  3   log2 of window length; window = 8 taps; only 3 is supported
// PORTS
//  clk      in   1            rising-edge clock, single clock domain
//  rst      in   1            synchronous, active-high reset
//  clear    in   1            synchronous flush of window and sum
//  x_valid  in   1            x_in qualifies this cycle
//  x_in     in   DATA_W       signed sample
//  y_valid  out  1            y_sum/y_avg valid this cycle (1-cycle pulse per sample)
//  y_sum    out  DATA_W+3     signed sum of the last 8 accepted samples
//  y_full   out  1            window holds 8 real samples
//  y_avg    out  DATA_W       signed rounded average (only with MAVG_ROUND_EN)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge) clears the following, and dominates all other inputs:
//    - delay line d[0..7], acc, and fill counter;
//    - y_valid=0, y_sum=0, y_full=0, y_avg=0.
//  - Accept: x_valid=1 and clear=0 -> on that edge:
//    - acc <= acc + sext(x_in) - sext(d[7]);
//    - d[0] <= x_in, d[i] <= d[i-1];
//    - fill <= min(fill+1, 8).
//  - Latency 1: y_valid=1 in the cycle after the accept edge.
//    - y_sum shows the updated acc and holds between accepts.
//  - x_valid=0: no shift, acc and y_sum hold, y_valid=0. Valid gaps of any length are allowed.
//  - Partial window: the delay line resets to 0, so before 8 accepts y_sum = sum of accepted samples only.
//    - y_full rises together with the y_valid of the 8th accept.
//    - y_full stays 1 until rst or clear.
//  - Arithmetic: every operand is sign-extended to DATA_W+3 bits.
//    - Range is -8*2^(DATA_W-1) .. 8*(2^(DATA_W-1)-1) (DATA_W=7: -512..504).
//    - No overflow is possible and none is saturated; the intermediate add/sub wraps harmlessly in DATA_W+3 bits.
//  - clear=1 (rst=0) behaves like reset for d, acc, fill, y_sum, y_full, y_avg, and forces y_valid=0.
//    - clear with x_valid=1 in the same cycle: clear wins and the sample is dropped.
//  - rst asserted mid-stream: takes effect on the next edge; in-flight sample is lost; no partial y_valid.
//  - The fill counter saturates at 8 and never wraps.
// CONFIGURATION
//  - MAVG_ROUND_EN defined:
//    - adds port y_avg = (acc_next + 4) >>> 3, round half toward +inf, truncated to DATA_W bits;
//    - y_avg updates with the same timing as y_sum.
//  - MAVG_ROUND_EN undefined: port y_avg and its adder are absent.
//  - y_sum and y_valid behaviour is identical either way.
// TESTING (DATA_W=7)
//  1 Reset, then 8 accepts of x=10 -> y_sum 10,20,..,80 one cycle after each; y_full=1 with 80.
//  2 Continue with x=0 x8 -> y_sum 70,60,..,0; y_full stays 1.
//  3 Extremes: 8 accepts of -64 -> y_sum=-512; then 8 of 63 -> y_sum=504; no wrap.
//  4 Insert random x_valid gaps into scenario 1:
//    - same y_sum sequence;
//    - y_valid only after accepts;
//    - y_sum held through gaps.
//  5 After 5 accepts of 10 assert clear with x_valid=1, x=7:
//    - next cycle y_sum=0, y_full=0, y_valid=0;
//    - then 3 accepts of 7 -> 7, 14, 21.
//  6 MAVG_ROUND_EN: sums 20, -512, 504, -20 -> y_avg 3, -64, 63, -2; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/moving_avg_8tap.sv
// moving_avg_8tap: recursive 8-tap boxcar (moving-sum) filter.
//
// Keeps a running sum of the last 8 accepted samples instead of an adder tree:
// each accepted sample is added and the sample leaving the window is subtracted.
//
// Optional feature macro: MAVG_ROUND_EN
//   Adds the y_avg output, the rounded average of the window.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; dominates every other input
//   clear    synchronous flush of window, sum and fill count; drops a same-cycle sample
//   x_valid  x_in is accepted this cycle
//   x_in     signed two's-complement sample
//   y_valid  one-cycle pulse, the cycle after each accept
//   y_sum    signed sum of the last 8 accepted samples; holds between accepts
//   y_full   window holds 8 real samples; stays set until rst or clear
//   y_avg    (MAVG_ROUND_EN only) (sum + 4) >>> 3, truncated to DATA_W bits
module moving_avg_8tap #(
  parameter int unsigned DATA_W  = 7,
  parameter int unsigned TAPS_LG = 3   // only 3 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_in,
  output logic              y_valid,
  output logic [DATA_W+2:0] y_sum,
`ifdef MAVG_ROUND_EN
  output logic              y_full,
  output logic [DATA_W-1:0] y_avg
`else
  output logic              y_full
`endif
);

  localparam int unsigned Taps  = 1 << TAPS_LG;
  localparam int unsigned SumW  = DATA_W + 3;
  localparam int unsigned FillW = TAPS_LG + 1;
  localparam logic [FillW-1:0] FillMax = FillW'(Taps);

  logic [DATA_W-1:0]      d_q [Taps];
  logic [DATA_W-1:0]      d_d [Taps];
  logic signed [SumW-1:0] acc_q, acc_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic                   y_valid_q, y_valid_d;

  logic signed [SumW-1:0] x_ext;
  logic signed [SumW-1:0] old_ext;

  // The wide accumulator can never overflow, so plain modular add/sub is exact.
  assign x_ext   = {{3{x_in[DATA_W-1]}}, x_in};
  assign old_ext = {{3{d_q[Taps-1][DATA_W-1]}}, d_q[Taps-1]};

  always_comb begin
    d_d       = d_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    y_valid_d = 1'b0;
    if (clear) begin
      for (int unsigned i = 0; i < Taps; i++) begin
        d_d[i] = '0;
      end
      acc_d  = '0;
      fill_d = '0;
    end else if (x_valid) begin
      d_d[0] = x_in;
      for (int unsigned i = 1; i < Taps; i++) begin
        d_d[i] = d_q[i-1];
      end
      acc_d     = acc_q + x_ext - old_ext;
      y_valid_d = 1'b1;
      if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Taps; i++) begin
        d_q[i] <= '0;
      end
      acc_q     <= '0;
      fill_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      d_q       <= d_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_sum   = acc_q;
  assign y_full  = (fill_q == FillMax);

`ifdef MAVG_ROUND_EN
  localparam logic signed [SumW-1:0] RndBias = 4;

  logic [DATA_W-1:0] y_avg_q, y_avg_d;

  // Round half toward +inf: bias by half an LSB, then arithmetic shift.
  always_comb begin
    y_avg_d = y_avg_q;
    if (clear) begin
      y_avg_d = '0;
    end else if (x_valid) begin
      y_avg_d = DATA_W'((acc_d + RndBias) >>> 3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_avg_q <= '0;
    end else begin
      y_avg_q <= y_avg_d;
    end
  end

  assign y_avg = y_avg_q;
`endif

endmodule
